// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU datapath (priority) and a debug reader.
// A starvation counter steals one CPU cycle so a pending debug read always completes.
module dmem_port_arbiter #(
   parameter int AW       = 10,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_en_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [31:0]   cpu_wdata_i,
   output logic [31:0]   cpu_rdata_o,
   output logic          cpu_stall_o,
   input  logic          dbg_req_i,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [31:0]   dbg_rdata_o,
   output logic          dbg_ack_o,
   output logic [15:0]   dbg_cnt_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, FORCE, ACK} state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          dbg_own;

   // Debug owns the port on a free IDLE cycle or during the stolen FORCE cycle.
   assign dbg_own     = ((state_q == IDLE) && dbg_req_i && !cpu_en_i) || (state_q == FORCE);
   assign mem_addr_o  = dbg_own ? dbg_addr_i : cpu_addr_i;
   assign mem_we_o    = !dbg_own && cpu_en_i && cpu_we_i;
   assign mem_wdata_o = cpu_wdata_i;
   assign cpu_rdata_o = mem_rdata_i;
   assign cpu_stall_o = (state_q == FORCE);
   assign dbg_ack_o   = (state_q == ACK);
   assign dbg_rdata_o = rdata_q;
   assign dbg_cnt_o   = cnt_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (dbg_req_i) begin
               if (!cpu_en_i) begin
                  rdata_d = mem_rdata_i;
                  state_d = ACK;
               end else begin
                  wait_d = wait_q + 1'b1;
                  if (wait_d == WW'(MAX_WAIT)) state_d = FORCE;
               end
            end else begin
               wait_d = '0;
            end
         end
         FORCE: begin
            rdata_d = mem_rdata_i;
            state_d = ACK;
         end
         ACK: begin
            cnt_d   = cnt_q + 16'd1;
            wait_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the arbitration rules; the bench also plays the memory.
module tb_dmem_port_arbiter;

   localparam int AW       = 10;
   localparam int MAX_WAIT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_en = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0;
   logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic [31:0]   cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic          cpu_stall, dbg_ack, mem_we;
   logic [15:0]   dbg_cnt;
   logic [AW-1:0] mem_addr;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .cpu_en_i(cpu_en), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_rdata_o(dbg_rdata),
      .dbg_ack_o(dbg_ack), .dbg_cnt_o(dbg_cnt),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // Single-port memory: combinational read, synchronous write; pre_we is a bench back door.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic cyc(input logic en, input logic we, input logic [AW-1:0] ca,
                      input logic [31:0] wd, input logic req, input logic [AW-1:0] da);
      @(negedge clk);
      cpu_en = en; cpu_we = we; cpu_addr = ca; cpu_wdata = wd; dbg_req = req; dbg_addr = da;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; pre_we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
      n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", dbg_ack); end
      n_cmp++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", dbg_rdata); end
      n_cmp++; if (dbg_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", dbg_cnt); end
      do_reset();
   endtask

   task automatic test_idle_read();
      do_reset();
      preload(10'd5, 32'hDEADBEEF);
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
      n_cmp++; if (mem_addr !== 10'd5) begin n_bad++; $display("FAIL idle_addr got=%0d exp=5", mem_addr); end
      n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL idle_ack_c1 got=%b exp=0", dbg_ack); end
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
      n_cmp++; if (dbg_ack !== 1'b1) begin n_bad++; $display("FAIL idle_ack_c2 got=%b exp=1", dbg_ack); end
      n_cmp++; if (dbg_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL idle_rdata got=%h exp=deadbeef", dbg_rdata); end
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd5);
      n_cmp++; if (dbg_cnt !== 16'd1) begin n_bad++; $display("FAIL idle_cnt got=%0d exp=1", dbg_cnt); end
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall got=%b exp=0", cpu_stall); end
   endtask

   task automatic test_forced_slot();
      do_reset();
      preload(10'd7, 32'h0000_0777);
      for (int c = 1; c <= 10; c++) begin
         cyc(1'b1, 1'b0, 10'd100, 32'h0, 1'b1, 10'd7);
         n_cmp++; if (cpu_stall !== (c == 9)) begin n_bad++; $display("FAIL force_stall c=%0d got=%b exp=%b", c, cpu_stall, c == 9); end
         n_cmp++; if (dbg_ack !== (c == 10)) begin n_bad++; $display("FAIL force_ack c=%0d got=%b exp=%b", c, dbg_ack, c == 10); end
         n_cmp++; if (mem_addr !== ((c == 9) ? 10'd7 : 10'd100)) begin n_bad++; $display("FAIL force_owner c=%0d got=%0d", c, mem_addr); end
      end
      n_cmp++; if (dbg_rdata !== 32'h0000_0777) begin n_bad++; $display("FAIL force_rdata got=%h exp=00000777", dbg_rdata); end
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
   endtask

   task automatic test_force_store();
      do_reset();
      preload(10'd3, 32'h0000_0033);
      preload(10'd20, 32'h0);
      for (int c = 1; c <= 8; c++) cyc(1'b1, 1'b0, 10'd20, 32'hA5A5A5A5, 1'b1, 10'd3);
      cyc(1'b1, 1'b1, 10'd20, 32'hA5A5A5A5, 1'b1, 10'd3);
      n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL fstore_stall got=%b exp=1", cpu_stall); end
      n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL fstore_we_force got=%b exp=0", mem_we); end
      cyc(1'b1, 1'b1, 10'd20, 32'hA5A5A5A5, 1'b0, 10'd3);
      n_cmp++; if (mem[20] !== 32'h0) begin n_bad++; $display("FAIL fstore_dropped got=%h exp=0", mem[20]); end
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 10'd20) begin n_bad++; $display("FAIL fstore_reissue we=%b addr=%0d exp we=1 addr=20", mem_we, mem_addr); end
      n_cmp++; if (dbg_rdata !== 32'h0000_0033) begin n_bad++; $display("FAIL fstore_rdata got=%h exp=00000033", dbg_rdata); end
      cyc(1'b0, 1'b0, 10'd20, 32'h0, 1'b0, 10'd3);
      n_cmp++; if (mem[20] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL fstore_landed got=%h exp=a5a5a5a5", mem[20]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
         n_cmp++; if (dbg_ack !== (c % 2 == 0)) begin n_bad++; $display("FAIL b2b_ack c=%0d got=%b exp=%b", c, dbg_ack, c % 2 == 0); end
         n_cmp++; if (dbg_cnt !== 16'((c - 1) / 2)) begin n_bad++; $display("FAIL b2b_cnt c=%0d got=%0d exp=%0d", c, dbg_cnt, (c - 1) / 2); end
         n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall c=%0d got=%b exp=0", c, cpu_stall); end
      end
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd5);
   endtask

   task automatic test_withdraw();
      do_reset();
      for (int c = 1; c <= 5; c++) cyc(1'b1, 1'b0, 10'd50, 32'h0, 1'b1, 10'd9);
      cyc(1'b1, 1'b0, 10'd50, 32'h0, 1'b0, 10'd9);
      n_cmp++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL withdraw_idle ack=%b stall=%b exp 0 0", dbg_ack, cpu_stall); end
      // A fresh request must again see the full MAX_WAIT lost cycles before its forced slot.
      for (int c = 1; c <= MAX_WAIT + 1; c++) begin
         cyc(1'b1, 1'b0, 10'd50, 32'h0, 1'b1, 10'd9);
         n_cmp++; if (cpu_stall !== (c == MAX_WAIT + 1)) begin n_bad++; $display("FAIL withdraw_restart c=%0d got=%b exp=%b", c, cpu_stall, c == MAX_WAIT + 1); end
         n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL withdraw_ack c=%0d got=%b exp=0", c, dbg_ack); end
      end
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
   endtask

   task automatic test_reset_in_force();
      do_reset();
      preload(10'd5, 32'hDEADBEEF);
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
      cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd5);
      for (int c = 1; c <= MAX_WAIT + 1; c++) cyc(1'b1, 1'b0, 10'd1, 32'h0, 1'b1, 10'd5);
      n_cmp++; if (cpu_stall !== 1'b1 || dbg_cnt !== 16'd1) begin n_bad++; $display("FAIL rstf_pre stall=%b cnt=%0d exp 1 1", cpu_stall, dbg_cnt); end
      rst = 1'b1;
      #1;
      n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rstf_stall got=%b exp=0", cpu_stall); end
      n_cmp++; if (dbg_ack !== 1'b0) begin n_bad++; $display("FAIL rstf_ack got=%b exp=0", dbg_ack); end
      n_cmp++; if (dbg_cnt !== 16'd0) begin n_bad++; $display("FAIL rstf_cnt got=%0d exp=0", dbg_cnt); end
      n_cmp++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL rstf_rdata got=%h exp=0", dbg_rdata); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         cyc(1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 10'd5);
         n_cmp++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rstf_after c=%0d ack=%b stall=%b exp 0 0", c, dbg_ack, cpu_stall); end
      end
   endtask

   // Model: m_lost = cycles a pending request has lost to the CPU, m_force = a stolen
   // cycle is due now, m_ack = the previous cycle served a read.
   task automatic test_random();
      int m_lost = 0;
      bit m_force = 0, m_ack = 0, serve, nxt_force;
      logic [31:0] m_rdata = 32'h0;
      logic [15:0] m_cnt = 16'h0;
      logic [AW-1:0] exp_addr, da;
      logic en, we, req, exp_we;
      int nerr0;
      do_reset();
      da = '0;
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 9) < ((i < 300) ? 9 : 5));
         we  = $urandom_range(0, 1) == 1;
         req = $urandom_range(0, 9) < 7;
         if (!dbg_req) da = AW'($urandom_range(0, 15));
         cyc(en, we, AW'($urandom_range(0, 15)), $urandom, req, da);
         serve    = m_force || (!m_ack && req && !en);
         exp_addr = serve ? da : cpu_addr;
         exp_we   = !serve && en && we;
         nerr0 = n_bad;
         n_cmp++; if (cpu_stall !== m_force) begin n_bad++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, cpu_stall, m_force); end
         n_cmp++; if (dbg_ack !== m_ack) begin n_bad++; $display("FAIL rnd_ack i=%0d got=%b exp=%b", i, dbg_ack, m_ack); end
         n_cmp++; if (mem_addr !== exp_addr || mem_we !== exp_we) begin n_bad++; $display("FAIL rnd_port i=%0d addr=%0d we=%b exp addr=%0d we=%b", i, mem_addr, mem_we, exp_addr, exp_we); end
         n_cmp++; if (mem_wdata !== cpu_wdata || cpu_rdata !== mem[exp_addr]) begin n_bad++; $display("FAIL rnd_data i=%0d wdata=%h rdata=%h", i, mem_wdata, cpu_rdata); end
         n_cmp++; if (dbg_rdata !== m_rdata) begin n_bad++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, dbg_rdata, m_rdata); end
         n_cmp++; if (dbg_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, dbg_cnt, m_cnt); end
         if (n_bad != nerr0) break;
         if (serve) m_rdata = mem[da];
         nxt_force = 0;
         if (m_ack) begin
            m_lost = 0;
            m_cnt  = m_cnt + 16'd1;
         end else if (!m_force) begin
            if (!req) m_lost = 0;
            else if (en) begin
               m_lost++;
               if (m_lost == MAX_WAIT) nxt_force = 1;
            end
         end
         m_ack   = serve;
         m_force = nxt_force;
      end
   endtask

   initial begin
      test_reset();
      test_idle_read();
      test_forced_slot();
      test_force_store();
      test_back_to_back();
      test_withdraw();
      test_reset_in_force();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
